// File: rtl/dual_mem_port_sched_pkg.sv
// Shared types for the data-SRAM port scheduler: FSM states and read-routing tags.
package dual_mem_port_sched_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SECOND = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        ROUTE_NONE = 2'd0,
        ROUTE_I1   = 2'd1,
        ROUTE_I2   = 2'd2,
        ROUTE_BOTH = 2'd3
    } route_e;

    function automatic logic route_has_i1(input route_e r);
        return (r == ROUTE_I1) || (r == ROUTE_BOTH);
    endfunction

    function automatic logic route_has_i2(input route_e r);
        return (r == ROUTE_I2) || (r == ROUTE_BOTH);
    endfunction

endpackage

// File: rtl/dual_mem_port_sched.sv
// Shares the single data-SRAM port between the two issue slots (slot 1 first).
// Optional: MEM_SCHED_LOAD_FUSE_EN merges two same-word loads into one access.
module dual_mem_port_sched
    import dual_mem_port_sched_pkg::*;
#(
    parameter int ADDR_WD = 32,
    parameter int DATA_WD = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 ex_stall,

    input  logic                 req_en_i1,
    input  logic                 req_wen_i1,
    input  logic [DATA_WD/8-1:0] req_sel_i1,
    input  logic [ADDR_WD-1:0]   req_addr_i1,
    input  logic [DATA_WD-1:0]   req_wdata_i1,
    input  logic                 kill_i1,

    input  logic                 req_en_i2,
    input  logic                 req_wen_i2,
    input  logic [DATA_WD/8-1:0] req_sel_i2,
    input  logic [ADDR_WD-1:0]   req_addr_i2,
    input  logic [DATA_WD-1:0]   req_wdata_i2,
    input  logic                 kill_i2,

    output logic                 data_sram_en,
    output logic [DATA_WD/8-1:0] data_sram_wen,
    output logic [ADDR_WD-1:0]   data_sram_addr,
    output logic [DATA_WD-1:0]   data_sram_wdata,
    input  logic [DATA_WD-1:0]   data_sram_rdata,

    output logic                 stallreq_mem,
    output logic [DATA_WD-1:0]   rdata_i1,
    output logic [DATA_WD-1:0]   rdata_i2
);

    localparam int SEL_WD = DATA_WD / 8;

    state_e               state_q, state_d;
    route_e               route_q, route_d;
    logic                 last_wr_q, last_wr_d;
    logic [DATA_WD-1:0]   hold_q, hold_d;
    logic                 hold_v_q, hold_v_d;

    logic v1, v2, fuse;

    assign v1 = req_en_i1 & ~kill_i1;
    assign v2 = req_en_i2 & ~kill_i2 & ~kill_i1;

`ifdef MEM_SCHED_LOAD_FUSE_EN
    assign fuse = v1 & v2 & ~req_wen_i1 & ~req_wen_i2 &
                  (req_addr_i1[ADDR_WD-1:2] == req_addr_i2[ADDR_WD-1:2]);
`else
    assign fuse = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        route_d         = route_q;
        last_wr_d       = last_wr_q;
        hold_d          = hold_q;
        hold_v_d        = 1'b0;
        data_sram_en    = 1'b0;
        data_sram_wen   = '0;
        data_sram_addr  = '0;
        data_sram_wdata = '0;
        stallreq_mem    = 1'b0;

        if (rst || flush) begin
            state_d   = ST_IDLE;
            route_d   = ROUTE_NONE;
            last_wr_d = 1'b0;
            hold_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!ex_stall) begin
                        if (fuse) begin
                            data_sram_en   = 1'b1;
                            data_sram_addr = {req_addr_i1[ADDR_WD-1:2], 2'b00};
                            route_d        = ROUTE_BOTH;
                            last_wr_d      = 1'b0;
                        end else if (v1) begin
                            data_sram_en    = 1'b1;
                            data_sram_wen   = req_wen_i1 ? req_sel_i1 : {SEL_WD{1'b0}};
                            data_sram_addr  = req_addr_i1;
                            data_sram_wdata = req_wdata_i1;
                            route_d         = ROUTE_I1;
                            last_wr_d       = req_wen_i1;
                            if (v2) begin
                                stallreq_mem = 1'b1;
                                state_d      = ST_SECOND;
                            end
                        end else if (v2) begin
                            data_sram_en    = 1'b1;
                            data_sram_wen   = req_wen_i2 ? req_sel_i2 : {SEL_WD{1'b0}};
                            data_sram_addr  = req_addr_i2;
                            data_sram_wdata = req_wdata_i2;
                            route_d         = ROUTE_I2;
                            last_wr_d       = req_wen_i2;
                        end else begin
                            route_d = ROUTE_NONE;
                        end
                    end
                end
                ST_SECOND: begin
                    // EX is frozen by our stall, so the slot-2 fields are still the pair's.
                    data_sram_en    = v2;
                    data_sram_wen   = (v2 && req_wen_i2) ? req_sel_i2 : {SEL_WD{1'b0}};
                    data_sram_addr  = req_addr_i2;
                    data_sram_wdata = req_wdata_i2;
                    route_d         = v2 ? ROUTE_I2 : ROUTE_NONE;
                    last_wr_d       = req_wen_i2;
                    if (route_q == ROUTE_I1 && !last_wr_q) begin
                        hold_d   = data_sram_rdata;
                        hold_v_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                    route_d = ROUTE_NONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            route_q   <= ROUTE_NONE;
            last_wr_q <= 1'b0;
            hold_q    <= '0;
            hold_v_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            route_q   <= route_d;
            last_wr_q <= last_wr_d;
            hold_q    <= hold_d;
            hold_v_q  <= hold_v_d;
        end
    end

    always_comb begin
        rdata_i1 = '0;
        rdata_i2 = '0;
        if (!rst) begin
            if (hold_v_q) begin
                rdata_i1 = hold_q;
            end else if (route_has_i1(route_q)) begin
                rdata_i1 = data_sram_rdata;
            end
            if (route_has_i2(route_q)) begin
                rdata_i2 = data_sram_rdata;
            end
        end
    end

endmodule
